// File: rtl/sr_pkg.sv
// sr_pkg: shared FSM encoding, op codes and default sizing for the SR bank arbiter.
package sr_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, RECOVER} state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam int DEF_N_BITS    = 4;
    localparam int DEF_PULSE_LEN = 2;

endpackage

// File: rtl/sr_rr_arb2.sv
// sr_rr_arb2: two-requester round-robin arbiter; bit 0 is A, bit 1 is B.
module sr_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_b;

    // On a tie the requester that did not win last time takes it.
    assign gnt[0] = req[0] & (~req[1] | last_b);
    assign gnt[1] = req[1] & (~req[0] | ~last_b);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            last_b <= 1'b1;
        else if (en && |req)
            last_b <= gnt[1];

endmodule

// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter: arbitrates two requesters issuing set/reset pulses onto a shared SR bank.
module sr_bank_arbiter
    import sr_pkg::*;
#(
    parameter int N_BITS    = DEF_N_BITS,
    parameter int PULSE_LEN = DEF_PULSE_LEN,
    localparam int IW       = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [1:0]        op_a,
    input  logic [IW-1:0]     idx_a,
    input  logic              req_b,
    input  logic [1:0]        op_b,
    input  logic [IW-1:0]     idx_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              err,
    output logic [N_BITS-1:0] s_out,
    output logic [N_BITS-1:0] r_out,
    output logic              busy
);

    state_t              state;
    logic [3:0]          cnt;
    logic [1:0]          win;
    logic                can_take;
    logic [1:0]          op_w;
    logic [IW-1:0]       idx_w;
    logic                bad_w;
    logic                drive_w;
    logic [N_BITS-1:0]   bit_w;

    // The closing edge of RECOVER arbitrates too, giving one command per PULSE_LEN+1 cycles.
    assign can_take = (state == IDLE) || (state == RECOVER);

    sr_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (can_take),
        .req ({req_b, req_a}),
        .gnt (win)
    );

    assign op_w    = win[1] ? op_b : op_a;
    assign idx_w   = win[1] ? idx_b : idx_a;
    assign bad_w   = (op_w == OP_ILL) || (int'(idx_w) >= N_BITS);
    assign drive_w = |win && !bad_w && (op_w != OP_NOP);
    assign bit_w   = N_BITS'(1) << idx_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            s_out <= '0;
            r_out <= '0;
        end else begin
            gnt_a <= can_take & win[0];
            gnt_b <= can_take & win[1];
            err   <= can_take & |win & bad_w;
            case (state)
                IDLE, RECOVER: begin
                    s_out <= (drive_w && op_w == OP_SET) ? bit_w : '0;
                    r_out <= (drive_w && op_w == OP_RST) ? bit_w : '0;
                    state <= drive_w ? DRIVE : IDLE;
                    busy  <= drive_w;
                    cnt   <= drive_w ? 4'(PULSE_LEN - 1) : '0;
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state <= RECOVER;
                        s_out <= '0;
                        r_out <= '0;
                    end else
                        cnt <= cnt - 4'd1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    s_out <= '0;
                    r_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb_sr_bank_arbiter: directed vector table plus hand sequences for the SR bank arbiter.
module tb_sr_bank_arbiter;
    import sr_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a, req_b;
    logic [1:0] op_a, op_b, idx_a, idx_b;
    logic       gnt_a, gnt_b, err, busy;
    logic [3:0] s_out, r_out;
    logic       gnt_a3, gnt_b3, err3, busy3;
    logic [2:0] s3, r3;
    logic [11:0] obs;
    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    sr_bank_arbiter dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .op_a(op_a), .idx_a(idx_a),
        .req_b(req_b), .op_b(op_b), .idx_b(idx_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .err(err),
        .s_out(s_out), .r_out(r_out), .busy(busy)
    );

    // Three-bit bank so that index 3 is representable yet out of range.
    sr_bank_arbiter #(.N_BITS(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_a(req_a), .op_a(op_a), .idx_a(idx_a),
        .req_b(req_b), .op_b(op_b), .idx_b(idx_b),
        .gnt_a(gnt_a3), .gnt_b(gnt_b3), .err(err3),
        .s_out(s3), .r_out(r3), .busy(busy3)
    );

    assign obs = {gnt_a, gnt_b, err, busy, s_out, r_out};

    typedef struct {
        logic       ra;
        logic [1:0] oa, ia;
        logic       rb;
        logic [1:0] ob, ib;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(input logic ra, input logic [1:0] oa, input logic [1:0] ia,
                                input logic rb, input logic [1:0] ob, input logic [1:0] ib,
                                input logic [11:0] exp);
        vec_t v;
        v.ra = ra; v.oa = oa; v.ia = ia;
        v.rb = rb; v.ob = ob; v.ib = ib;
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    function automatic logic inv_ok(input logic [3:0] s, input logic [3:0] r, input logic ga, input logic gb);
        logic [3:0] d;
        d = s | r;
        return ((s & r) == 4'b0) && ((d & (d - 4'd1)) == 4'b0) && !(ga && gb);
    endfunction

    always @(negedge clk) begin
        total++;
        if (inv_ok(s_out, r_out, gnt_a, gnt_b) && inv_ok({1'b0, s3}, {1'b0, r3}, gnt_a3, gnt_b3))
            pass_cnt++;
        else
            $display("FAIL monitor: s=%b r=%b ga=%b gb=%b s3=%b r3=%b ga3=%b gb3=%b",
                     s_out, r_out, gnt_a, gnt_b, s3, r3, gnt_a3, gnt_b3);
    end

    task automatic idle_in();
        req_a = 1'b0; op_a = OP_NOP; idx_a = 2'd0;
        req_b = 1'b0; op_b = OP_NOP; idx_b = 2'd0;
    endtask

    initial begin
        logic seen;
        // Expected word layout: {gnt_a, gnt_b, err, busy, s_out[3:0], r_out[3:0]}
        tbl[0]  = mk(1, OP_SET, 2, 0, OP_NOP, 0, 12'b1001_0100_0000);
        tbl[1]  = mk(0, OP_NOP, 0, 0, OP_NOP, 0, 12'b0001_0100_0000);
        tbl[2]  = mk(0, OP_NOP, 0, 0, OP_NOP, 0, 12'b0001_0000_0000);
        tbl[3]  = mk(0, OP_NOP, 0, 0, OP_NOP, 0, 12'b0000_0000_0000);
        tbl[4]  = mk(0, OP_NOP, 0, 1, OP_ILL, 1, 12'b0110_0000_0000);
        tbl[5]  = mk(0, OP_NOP, 0, 0, OP_NOP, 0, 12'b0000_0000_0000);
        tbl[6]  = mk(0, OP_NOP, 0, 1, OP_NOP, 0, 12'b0100_0000_0000);
        tbl[7]  = mk(0, OP_NOP, 0, 0, OP_NOP, 0, 12'b0000_0000_0000);
        tbl[8]  = mk(1, OP_SET, 0, 1, OP_RST, 3, 12'b1001_0001_0000);
        tbl[9]  = mk(1, OP_SET, 0, 1, OP_RST, 3, 12'b0001_0001_0000);
        tbl[10] = mk(1, OP_SET, 0, 1, OP_RST, 3, 12'b0001_0000_0000);
        tbl[11] = mk(1, OP_SET, 0, 1, OP_RST, 3, 12'b0101_0000_1000);
        tbl[12] = mk(1, OP_SET, 0, 1, OP_RST, 3, 12'b0001_0000_1000);
        tbl[13] = mk(1, OP_SET, 0, 1, OP_RST, 3, 12'b0001_0000_0000);
        tbl[14] = mk(1, OP_SET, 0, 1, OP_RST, 3, 12'b1001_0001_0000);
        tbl[15] = mk(1, OP_SET, 0, 1, OP_RST, 3, 12'b0001_0001_0000);
        tbl[16] = mk(1, OP_SET, 0, 1, OP_RST, 3, 12'b0001_0000_0000);
        tbl[17] = mk(1, OP_SET, 0, 1, OP_RST, 3, 12'b0101_0000_1000);
        tbl[18] = mk(0, OP_NOP, 0, 0, OP_NOP, 0, 12'b0001_0000_1000);
        tbl[19] = mk(0, OP_NOP, 0, 0, OP_NOP, 0, 12'b0001_0000_0000);
        tbl[20] = mk(0, OP_NOP, 0, 0, OP_NOP, 0, 12'b0000_0000_0000);
        tbl[21] = mk(1, OP_SET, 1, 0, OP_NOP, 0, 12'b1001_0010_0000);
        tbl[22] = mk(0, OP_NOP, 0, 1, OP_SET, 2, 12'b0001_0010_0000);
        tbl[23] = mk(0, OP_NOP, 0, 1, OP_SET, 2, 12'b0001_0000_0000);
        tbl[24] = mk(0, OP_NOP, 0, 1, OP_SET, 2, 12'b0101_0100_0000);
        tbl[25] = mk(0, OP_NOP, 0, 0, OP_NOP, 0, 12'b0001_0100_0000);
        tbl[26] = mk(0, OP_NOP, 0, 0, OP_NOP, 0, 12'b0001_0000_0000);
        tbl[27] = mk(0, OP_NOP, 0, 0, OP_NOP, 0, 12'b0000_0000_0000);

        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", obs, 12'b0);
        chk("reset_state_n3", {6'b0, gnt_a3, gnt_b3, err3, busy3, s3[1:0]}, 12'b0);
        rst = 1'b0;

        // First tie after reset goes to A.
        req_a = 1'b1; req_b = 1'b1;
        @(posedge clk); #1;
        chk("first_tie_a", obs, 12'b1000_0000_0000);
        idle_in();

        for (int i = 0; i < 28; i++) begin
            req_a = tbl[i].ra; op_a = tbl[i].oa; idx_a = tbl[i].ia;
            req_b = tbl[i].rb; op_b = tbl[i].ob; idx_b = tbl[i].ib;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        // Reset asserted during the first DRIVE cycle of a set to bit 1.
        idle_in();
        req_a = 1'b1; op_a = OP_SET; idx_a = 2'd1;
        @(posedge clk); #1;
        chk("rst_pre_drive", obs, 12'b1001_0010_0000);
        idle_in();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_clear", obs, 12'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | gnt_a | gnt_b | busy | (|s_out) | (|r_out);
        end
        chk("rst_no_regrant", {11'b0, seen}, 12'b0);

        // Index 3 is out of range only for the three-bit bank.
        req_a = 1'b1; op_a = OP_SET; idx_a = 2'd3;
        @(posedge clk); #1;
        chk("range_n3", {6'b0, gnt_a3, err3, busy3, s3}, {6'b0, 6'b110_000});
        chk("range_n4", obs, 12'b1001_1000_0000);
        idle_in();
        @(posedge clk); #1;
        chk("range_n3_err_once", {6'b0, gnt_a3, err3, busy3, s3}, 12'b0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
